// File: rtl/mem_seq_unit.sv
// mem_seq_unit: byte-wide main memory behind the MDR, with a request/done
// sequencer that inserts a programmable number of wait states per access
// and a direct programming port used to preload programs before run.
module mem_seq_unit #(
    parameter int AW   = 16,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_req,
    input  logic          wr_req,
    output logic [7:0]    rd_data,
    output logic          busy,
    output logic          done,
    input  logic          prog_en,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    rd_data_q;

    // Latched access descriptor; only meaningful while busy, so never reset.
    logic          op_wr_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wd_q;

    // Storage; deliberately has no reset so programs survive clr.
    logic [7:0]    mem_q [DEPTH];

    logic          accept;
    logic          access_now;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // A new access starts only from IDLE, and the programming port wins.
    assign accept     = (state_q == ST_IDLE) && !prog_en && (rd_req || wr_req);
    // The access edge is the last WAIT cycle, once the counter has drained.
    assign access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Select the single memory write source; clr gates it so a reset that
    // overlaps a clock edge can never complete an aborted write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        if (clr) begin
            if ((state_q == ST_IDLE) && prog_en) begin
                mem_we    = 1'b1;
                mem_waddr = prog_addr;
                mem_wdata = prog_data;
            end else if (access_now && op_wr_q) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = wd_q;
            end
        end
    end

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Capture address, data and operation when a request is accepted;
    // write wins when both requests are high.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wd_q    <= wr_data;
            op_wr_q <= wr_req;
        end
    end

    // Sequencer FSM with registered busy/done/rd_data outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        cnt_q   <= WAIT_CNT;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!op_wr_q) begin
                            rd_data_q <= mem_q[addr_q];
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_seq_unit.sv
// Self-checking bench for mem_seq_unit: a WAIT=2 instance exercised with
// directed and random accesses against an array model, plus a WAIT=0
// instance for the back-to-back held-request timing.
module tb_mem_seq_unit;

    localparam int AW   = 4;
    localparam int WT   = 2;

    logic          clk = 1'b0;
    logic          clr;
    logic [AW-1:0] addr;
    logic [7:0]    wr_data;
    logic          rd_req;
    logic          wr_req;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic          prog_en;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;

    logic [AW-1:0] z_addr;
    logic [7:0]    z_wr_data;
    logic          z_rd_req;
    logic          z_wr_req;
    logic [7:0]    z_rd_data;
    logic          z_busy;
    logic          z_done;
    logic          z_prog_en;
    logic [AW-1:0] z_prog_addr;
    logic [7:0]    z_prog_data;

    int            checks = 0;
    int            errors = 0;

    logic [7:0]    ref_mem [16];
    logic [7:0]    ref_rd;

    always #5 clk = ~clk;

    mem_seq_unit #(.AW(AW), .WAIT(WT)) u_dut (
        .clk(clk), .clr(clr), .addr(addr), .wr_data(wr_data),
        .rd_req(rd_req), .wr_req(wr_req), .rd_data(rd_data),
        .busy(busy), .done(done), .prog_en(prog_en),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    mem_seq_unit #(.AW(AW), .WAIT(0)) u_dut0 (
        .clk(clk), .clr(clr), .addr(z_addr), .wr_data(z_wr_data),
        .rd_req(z_rd_req), .wr_req(z_wr_req), .rd_data(z_rd_data),
        .busy(z_busy), .done(z_done), .prog_en(z_prog_en),
        .prog_addr(z_prog_addr), .prog_data(z_prog_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_en = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // One complete access; scrambles addr/wr_data once busy to show they are ignored.
    task automatic access(input bit w, input bit r, input logic [AW-1:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        addr = a; wr_data = d; wr_req = w; rd_req = r;
        @(posedge clk); #1;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("no_early_done", {31'd0, done}, 32'd0);
        addr = AW'($urandom); wr_data = 8'($urandom); wr_req = 1'b0; rd_req = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, WT + 1);
        if (w) ref_mem[a] = d;
        else   ref_rd = ref_mem[a];
        chk("rd_data", {24'd0, rd_data}, {24'd0, ref_rd});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("rd_data_hold", {24'd0, rd_data}, {24'd0, ref_rd});
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int n;
        int pulses [$];
        clr = 1'b0;
        addr = '0; wr_data = '0; rd_req = 1'b0; wr_req = 1'b0;
        prog_en = 1'b0; prog_addr = '0; prog_data = '0;
        z_addr = '0; z_wr_data = '0; z_rd_req = 1'b0; z_wr_req = 1'b0;
        z_prog_en = 1'b0; z_prog_addr = '0; z_prog_data = '0;
        ref_rd = 8'h00;

        // Reset and idle
        repeat (3) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rst_rd_data", {24'd0, rd_data}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        watch_no_done("idle_no_done", 10);

        // Preload everything that will ever be read
        for (int i = 0; i < 16; i++) prog(AW'(i), 8'($urandom) | 8'h80);

        // Program and read
        prog(4'h3, 8'h06);
        access(1'b0, 1'b1, 4'h3, 8'h00);
        chk("prog_read", {24'd0, rd_data}, 32'h06);

        // Asynchronous reset mid-cycle clears outputs without a clock
        @(posedge clk); #3;
        clr = 1'b0;
        #1;
        chk("async_rd_data", {24'd0, rd_data}, 32'h0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        ref_rd = 8'h00;
        watch_no_done("post_rst_no_done", 10);

        // Write then read; memory survived the reset
        access(1'b0, 1'b1, 4'h3, 8'h00);
        chk("mem_survives_rst", {24'd0, rd_data}, 32'h06);
        access(1'b1, 1'b0, 4'h5, 8'h02);
        access(1'b0, 1'b1, 4'h5, 8'h00);
        chk("write_read", {24'd0, rd_data}, 32'h02);

        // Simultaneous requests: write wins, rd_data untouched
        access(1'b1, 1'b1, 4'h7, 8'hA5);
        chk("both_rd_unchanged", {24'd0, rd_data}, 32'h02);
        access(1'b0, 1'b1, 4'h7, 8'h00);
        chk("both_wrote", {24'd0, rd_data}, 32'hA5);

        // Abort an in-flight write with clr during WAIT
        prog(4'h9, 8'h11);
        @(negedge clk);
        addr = 4'h9; wr_data = 8'h77; wr_req = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_rise", {31'd0, busy}, 32'd1);
        wr_req = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        ref_rd = 8'h00;
        watch_no_done("abort_no_done", 10);
        access(1'b0, 1'b1, 4'h9, 8'h00);
        chk("abort_mem_kept", {24'd0, rd_data}, 32'h11);

        // prog_en while busy is ignored
        @(negedge clk);
        addr = 4'h3; rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        prog_en = 1'b1; prog_addr = 4'h4; prog_data = ~ref_mem[4];
        @(negedge clk);
        prog_en = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_prog_done_seen", {31'd0, done}, 32'd1);
        ref_rd = ref_mem[3];
        @(posedge clk); #1;
        access(1'b0, 1'b1, 4'h4, 8'h00);

        // Random accesses against the array model
        for (int k = 0; k < 24; k++) begin
            int op;
            op = $urandom_range(0, 2);
            access(op != 0, op != 1, AW'($urandom), 8'($urandom));
        end

        // WAIT=0 instance: 2-cycle read, held request repeats every 3 cycles
        @(negedge clk);
        z_prog_en = 1'b1; z_prog_addr = 4'h2; z_prog_data = 8'h5C;
        @(negedge clk);
        z_prog_en = 1'b0;
        z_addr = 4'h2; z_rd_req = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk("z_busy_rise", {31'd0, z_busy}, 32'd1);
            if (z_done === 1'b1) begin
                pulses.push_back(c);
                chk("z_rd_data", {24'd0, z_rd_data}, 32'h5C);
            end
        end
        z_rd_req = 1'b0;
        chk("z_pulse_count", pulses.size(), 5);
        if (pulses.size() > 0) chk("z_first_latency", pulses[0], 1);
        for (int p = 1; p < pulses.size(); p++) chk("z_period", pulses[p] - pulses[p-1], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
